// File: rtl/hex_game_display.sv
// Move-entry front end: decodes key strokes into a letter+number move and drives active-low 7-seg digits.
// All outputs registered, one cycle after the sampling edge; no backpressure, keys are single-cycle strobes.
module hex_game_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int BLINK_DIV     = 13500000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                    clock27,
  input  logic                    reset,
  input  logic                    player_turn,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  input  logic                    error_flag,
  output logic                    move_valid,
  output logic [2:0]              move_letter,
  output logic [3:0]              move_number,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  typedef enum logic [1:0] {EMPTY, LETTER, BOTH, BLINK} state_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  state_t                  state_q, state_d;
  logic [2:0]              letter_q, letter_d;
  logic [3:0]              number_q, number_d;
  logic                    has_let_q, has_let_d;
  logic                    has_num_q, has_num_d;
  logic                    player_q, player_d;
  logic [23:0]             blink_cnt_q, blink_cnt_d;
  logic [3:0]              tog_q, tog_d;
  logic                    mv_q, mv_d;
  logic [2:0]              ml_q, ml_d;
  logic [3:0]              mn_q, mn_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  logic is_digit, is_letter, is_clear, is_enter, player_chg, show;

  function automatic logic [6:0] digit_glyph(input logic [3:0] n);
    case (n)
      4'd0:    digit_glyph = 7'b1000000;
      4'd1:    digit_glyph = 7'b1111001;
      4'd2:    digit_glyph = 7'b0100100;
      4'd3:    digit_glyph = 7'b0110000;
      4'd4:    digit_glyph = 7'b0011001;
      4'd5:    digit_glyph = 7'b0010010;
      4'd6:    digit_glyph = 7'b0000010;
      4'd7:    digit_glyph = 7'b1111000;
      4'd8:    digit_glyph = 7'b0000000;
      4'd9:    digit_glyph = 7'b0010000;
      default: digit_glyph = BLANK;
    endcase
  endfunction

  function automatic logic [6:0] letter_glyph(input logic [2:0] l);
    case (l)
      3'd0:    letter_glyph = 7'b0001000;
      3'd1:    letter_glyph = 7'b0000011;
      3'd2:    letter_glyph = 7'b1000110;
      3'd3:    letter_glyph = 7'b0100001;
      3'd4:    letter_glyph = 7'b0000110;
      3'd5:    letter_glyph = 7'b0001110;
      3'd6:    letter_glyph = 7'b1000010;
      default: letter_glyph = 7'b0001001;
    endcase
  endfunction

  assign is_digit   = (key_code <= 5'd9);
  assign is_letter  = (key_code[4:3] == 2'b10);
  assign is_clear   = (key_code == 5'd24);
  assign is_enter   = (key_code == 5'd25);
  assign player_chg = (player_turn != player_q);

  always_comb begin
    state_d     = state_q;
    letter_d    = letter_q;
    number_d    = number_q;
    has_let_d   = has_let_q;
    has_num_d   = has_num_q;
    player_d    = player_turn;
    blink_cnt_d = blink_cnt_q;
    tog_d       = tog_q;
    mv_d        = 1'b0;
    ml_d        = ml_q;
    mn_d        = mn_q;

    // Priority: error, then blink timing, then player change, then keys.
    if (error_flag) begin
      state_d     = BLINK;
      blink_cnt_d = '0;
      tog_d       = '0;
    end else if (state_q == BLINK) begin
      if (blink_cnt_q == 24'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        if (tog_q == 4'(BLINK_TOGGLES - 1)) begin
          state_d   = EMPTY;
          tog_d     = '0;
          has_let_d = 1'b0;
          has_num_d = 1'b0;
          letter_d  = '0;
          number_d  = '0;
        end else begin
          tog_d = tog_q + 4'd1;
        end
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
      end
    end else if (player_chg) begin
      state_d   = EMPTY;
      has_let_d = 1'b0;
      has_num_d = 1'b0;
      letter_d  = '0;
      number_d  = '0;
    end else if (key_valid) begin
      case (state_q)
        EMPTY: if (is_letter) begin
          letter_d  = key_code[2:0];
          has_let_d = 1'b1;
          state_d   = LETTER;
        end
        LETTER: begin
          if (is_letter) begin
            letter_d = key_code[2:0];
          end else if (is_digit) begin
            number_d  = key_code[3:0];
            has_num_d = 1'b1;
            state_d   = BOTH;
          end else if (is_clear) begin
            has_let_d = 1'b0;
            letter_d  = '0;
            state_d   = EMPTY;
          end
        end
        BOTH: begin
          if (is_digit) begin
            number_d = key_code[3:0];
          end else if (is_clear) begin
            has_num_d = 1'b0;
            number_d  = '0;
            state_d   = LETTER;
          end else if (is_enter) begin
            mv_d      = 1'b1;
            ml_d      = letter_q;
            mn_d      = number_q;
            has_let_d = 1'b0;
            has_num_d = 1'b0;
            letter_d  = '0;
            number_d  = '0;
            state_d   = EMPTY;
          end
        end
        default: ;
      endcase
    end

    // Odd half-periods of a blink show the entry; even ones (starting at 0) blank it.
    show          = (state_d != BLINK) || tog_d[0];
    hex_d         = '1;
    hex_d[13:7]   = (has_num_d && show) ? digit_glyph(number_d) : BLANK;
    hex_d[20:14]  = (has_let_d && show) ? letter_glyph(letter_d) : BLANK;
    hex_d[27:21]  = player_d ? 7'b0100100 : 7'b1111001;
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      state_q     <= EMPTY;
      letter_q    <= '0;
      number_q    <= '0;
      has_let_q   <= 1'b0;
      has_num_q   <= 1'b0;
      player_q    <= 1'b0;
      blink_cnt_q <= '0;
      tog_q       <= '0;
      mv_q        <= 1'b0;
      ml_q        <= '0;
      mn_q        <= '0;
      hex_q       <= '1;
    end else begin
      state_q     <= state_d;
      letter_q    <= letter_d;
      number_q    <= number_d;
      has_let_q   <= has_let_d;
      has_num_q   <= has_num_d;
      player_q    <= player_d;
      blink_cnt_q <= blink_cnt_d;
      tog_q       <= tog_d;
      mv_q        <= mv_d;
      ml_q        <= ml_d;
      mn_q        <= mn_d;
      hex_q       <= hex_d;
    end
  end

  assign move_valid  = mv_q;
  assign move_letter = ml_q;
  assign move_number = mn_q;
  assign hex_out     = hex_q;

endmodule

// File: doc/hex_game_display.md
Name: hex_game_display

Overview:
Parametrised successor to the board's fixed 4-digit HEX controller. It drives NUM_DIGITS active-low seven-segment digits showing the current player and the move being typed (letter + number) from decoded keyboard strokes. It also owns entry editing (clear/enter), emits a validated move to the game logic, and blinks the entry on an error indication.

Parameters:
NUM_DIGITS, 4, number of seven-segment digits driven; legal range 4..8.
BLINK_DIV, 13500000, clock cycles per blink half-period (0.5 s at 27 MHz); legal range 1..2^24-1.
BLINK_TOGGLES, 6, blink half-periods before error mode exits; legal range 2..15.

Ports:
clock27  in  1  system clock, 27 MHz
reset  in  1  synchronous, active-high
player_turn  in  1  0 = player 1, 1 = player 2
key_valid  in  1  one-cycle strobe; key_code is valid this cycle
key_code  in  5  0..9 = digit; 16..23 = letter A..H; 24 = clear; 25 = enter; all other codes ignored
error_flag  in  1  one-cycle strobe from game logic: last move rejected
move_valid  out  1  one-cycle pulse: move_letter/move_number are valid
move_letter  out  3  letter index, 0 = A .. 7 = H
move_number  out  4  digit 0..9
hex_out  out  7*NUM_DIGITS  digit i occupies bits [7i+6:7i]; bit0 = seg a .. bit6 = seg g; 0 = segment lit

Behaviour:
- All outputs are registered. Every input effect appears on the outputs one clock after the sampling edge.
- Reset values:
  - FSM = EMPTY; stored letter and number = 0; blink counter and toggle counter = 0.
  - move_valid = 0, move_letter = 0, move_number = 0.
  - hex_out = all ones (all digits blank).
  - player_turn register = 0. The first cycle after reset shows "1" on digit 3.
- Digit map:
  - Digit 0 is always blank.
  - Digit 1 shows the number when present, otherwise blank.
  - Digit 2 shows the letter when present, otherwise blank.
  - Digit 3 shows the player: "1" = 1111001, "2" = 0100100 (bit6..bit0).
  - Digits 4..NUM_DIGITS-1 are blank.
- Digit glyphs (bit6..bit0):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Letter glyphs (bit6..bit0):
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001.
  - E = 0000110, F = 0001110, G = 1000010, H = 0001001.
- FSM states: EMPTY, LETTER, BOTH, BLINK. Transitions are evaluated only when key_valid = 1, except for error_flag and player change.
  - EMPTY:
    - letter → store it, go to LETTER.
    - digit, clear, enter → ignored.
  - LETTER:
    - letter → replace the stored letter.
    - digit → store it, go to BOTH.
    - clear → go to EMPTY.
    - enter → ignored.
  - BOTH:
    - digit → replace the stored number.
    - letter → ignored.
    - clear → drop the number, go to LETTER.
    - enter → on the next cycle, move_valid = 1 with move_letter and move_number loaded, FSM goes to EMPTY and digits 1–2 blank.
  - BLINK:
    - key_valid is ignored.
    - Digits 1–2 alternate between the stored glyphs and blank every BLINK_DIV cycles, starting with blank.
    - After BLINK_TOGGLES half-periods, go to EMPTY and clear the stored letter and number.
- Error handling:
  - error_flag = 1 in any state → go to BLINK, reset both counters, hold the stored letter and number.
  - error_flag during BLINK restarts the blink sequence.
  - error_flag and key_valid in the same cycle: error wins and the key is dropped.
- Player change: when the registered player_turn differs from the new sample, digit 3 updates.
  - If the FSM is in LETTER or BOTH, it goes to EMPTY and the entry is cleared.
  - If the FSM is in BLINK, blinking continues.
  - If key_valid arrives in the same cycle, the player change wins.
- move_valid is never high for two consecutive cycles. move_letter and move_number hold their last value between pulses.
- Reset mid-blink or mid-entry returns every output to its reset value on the next edge.

Test Plan:
1. Apply reset, then run 2 cycles with player_turn = 0 → hex_out[27:21] = 1111001, hex_out[20:0] = all ones, move_valid = 0.
2. Keys C(18), 7, enter on separate cycles → after C, digit 2 = 1000110; after 7, digit 1 = 1111000; one cycle after enter, move_valid = 1 with move_letter = 2, move_number = 7, then digits 1–2 blank.
3. Keys A(16), 3, clear, clear, enter → digits 1–2 blank and move_valid never asserts; then 5 alone → ignored, FSM stays EMPTY.
4. Run with BLINK_DIV = 4, BLINK_TOGGLES = 4. Keys B, 9, then error_flag → digits 1–2 blank for 4 cycles, show b/9 for 4 cycles, repeat; after 16 cycles, EMPTY with digits blank. Keys sent during blink are ignored.
5. Key E with error_flag in the same cycle → BLINK entered and E not stored. Key H in LETTER with player_turn changing to 1 in the same cycle → digit 3 = 0100100 and entry cleared.
6. Run with NUM_DIGITS = 6 and a full entry → digits 4 and 5 remain 1111111. Assert reset mid-blink → next cycle all reset values.
